uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Byte-serial UART transmitter: the responder end of the MMU's UART data path.
- Accepts a one-cycle `uart_write` strobe plus byte, buffers it in a small FIFO, and shifts 8N1 frames out on `tx`.
- Drives `uart_busy` back to the MMU. The MMU gates writes with it and returns it as bit 0 of the status word at 0x00004004.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 4, TX buffer entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- uart_write  input  1  one-cycle write strobe from the MMU.
- data_in  input  8  byte to send; the MMU drives data_from_cpu[7:0]. Sampled when uart_write is high.
- uart_busy  output  1  FIFO full; further writes are not accepted.
- tx  output  1  serial line; idle high; registered.
- tx_idle  output  1  high when the FIFO is empty and no frame is in flight.

Behaviour:
- Reset, sampled when rst_n=0 at an edge:
  - tx=1, uart_busy=0, tx_idle=1.
  - FIFO pointers and count cleared; FSM=IDLE; baud and bit counters cleared.
  - Reset mid-frame aborts the frame: tx returns to 1 at that edge, and all buffered bytes are discarded.
- Push:
  - Occurs when uart_write=1 and count<FIFO_DEPTH, at the edge.
  - A write while full is silently dropped, even if a pop occurs the same cycle.
- Count and flags:
  - Simultaneous push and pop leaves count unchanged.
  - uart_busy = (count==FIFO_DEPTH), registered, updated the same edge as count.
  - tx_idle = (count==0) and FSM==IDLE, registered.
- FSM states IDLE, START, DATA, STOP. Baud counter runs 0..CLKS_PER_BIT-1; a bit period ends when it reaches CLKS_PER_BIT-1.
- IDLE:
  - tx=1.
  - If count>0: pop the head into shift register, tx<=0, baud counter<=0, go to START, all at the same edge.
  - Latency: a byte pushed at edge N into an empty, idle block is popped and drives tx low at edge N+1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then present bit 0 and go to DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - A 3-bit counter tracks the bit index; after bit 7 completes, tx<=1 and go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At end of period, if count>0: pop, tx<=0, go to START directly, with no idle gap between frames. Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles; tx never glitches within a bit period.
- Data captured in the FIFO is immutable; changes on data_in while uart_write=0 have no effect.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Single byte: reset, then uart_write=1, data_in=0x55 for one cycle.
   - tx falls one edge later.
   - Sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total).
   - tx_idle rises after the stop bit; uart_busy stays 0.
2. Back-to-back: write 0xA5, then write 0x3C while 0xA5 is in DATA.
   - 80 contiguous cycles: start, 1,0,1,0,0,1,0,1, stop, start, 0,0,1,1,1,1,0,0, stop.
   - No idle cycle between the two frames.
3. Fill/overflow: writes 0x01..0x06 on six consecutive cycles, with the MMU gate bypassed.
   - 0x01 popped at edge 1; count reaches 4 at the fifth push; uart_busy=1 from that edge.
   - 0x06 dropped.
   - Exactly five frames 0x01..0x05 emitted.
   - uart_busy falls at the edge 0x02 is popped (end of frame 1).
4. Simultaneous push/pop at boundary: hold FIFO at count=3; issue a write on the exact cycle STOP ends.
   - Count stays 3; uart_busy stays 0; both bytes are sent in order.
5. Reset mid-frame: rst_n=0 for one cycle during data bit 3 of 0xFF, with 2 bytes queued.
   - tx=1 at that edge; uart_busy=0; tx_idle=1.
   - No further frames until a new write.
6. Data stability: toggle data_in every cycle with uart_write=0 during a frame of 0x81.
   - Transmitted bits are exactly 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-buffered 8N1 UART transmitter with busy/idle flags
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_write,
  input  logic [7:0] data_in,
  output logic       uart_busy,
  output logic       tx,
  output logic       tx_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  state_t        state;
  state_t        state_next;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift_q;
  logic [7:0]    shift_next;
  logic          tx_next;
  logic          pop;
  logic          push;
  logic          baud_done;

  // A write into a full buffer is dropped, even when a pop frees a slot this cycle.
  assign push      = uart_write && (count != DEPTH_C);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // Frame sequencing: next state, line level, counters and when to pop the buffer.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_q;
    tx_next    = tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          tx_next    = 1'b0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift_q[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift_q[7:1]};
            tx_next    = shift_q[1];
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (count != '0) begin
            // Chain straight into the next start bit so frames are gapless.
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Buffer storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and status flags; reset discards anything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      uart_busy <= 1'b0;
      tx_idle   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      uart_busy <= (count_next == DEPTH_C);
      tx_idle   <= (count_next == '0) && (state_next == IDLE);
    end
  end

  // Serial state register; reset aborts any frame and forces the line high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift_q  <= shift_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-timeline model
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       uart_busy;
  logic       tx;
  logic       tx_idle;

  int compared = 0;
  int mismatched = 0;

  // Reference model: buffered bytes, and the byte on the wire with the edge its start bit began.
  logic [7:0] q [$];
  logic [7:0] m_cur = 8'h00;
  bit         m_in_frame = 1'b0;
  int         m_start = 0;
  int         edge_cnt = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_write (uart_write),
    .data_in    (data_in),
    .uart_busy  (uart_busy),
    .tx         (tx),
    .tx_idle    (tx_idle)
  );

  always #5 clk = ~clk;

  function automatic logic exp_line();
    int off;
    int k;
    if (!m_in_frame) return 1'b1;
    off = edge_cnt - m_start;
    k = off / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
    int sz;
    bit acc;
    if (!r) begin
      q.delete();
      m_in_frame = 1'b0;
      return;
    end
    sz = q.size();
    acc = w && (sz < DEPTH);
    if (m_in_frame && (edge_cnt - m_start == FRAME)) m_in_frame = 1'b0;
    if (!m_in_frame && sz > 0) begin
      m_cur = q.pop_front();
      m_start = edge_cnt;
      m_in_frame = 1'b1;
    end
    if (acc) q.push_back(d);
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic e_tx;
    logic e_busy;
    logic e_idle;
    uart_write = w;
    data_in = d;
    rst_n = r;
    @(posedge clk);
    edge_cnt++;
    model_edge(w, d, r);
    e_tx = exp_line();
    e_busy = (q.size() == DEPTH);
    e_idle = (q.size() == 0) && !m_in_frame;
    #1;
    compared++;
    assert (tx === e_tx) else begin
      mismatched++;
      $error("FAIL tx edge=%0d observed=%b expected=%b", edge_cnt, tx, e_tx);
    end
    compared++;
    assert (uart_busy === e_busy) else begin
      mismatched++;
      $error("FAIL uart_busy edge=%0d observed=%b expected=%b", edge_cnt, uart_busy, e_busy);
    end
    compared++;
    assert (tx_idle === e_idle) else begin
      mismatched++;
      $error("FAIL tx_idle edge=%0d observed=%b expected=%b", edge_cnt, tx_idle, e_idle);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b1);
  endtask

  initial begin
    int pct;
    int guard;

    // Reset state.
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Single byte 0x55 followed by a full frame and idle recovery.
    cycle(1'b1, 8'h55, 1'b1);
    idle_cycles(FRAME + 4);

    // Back-to-back frames: second write lands while the first is in DATA.
    cycle(1'b1, 8'hA5, 1'b1);
    idle_cycles(10);
    cycle(1'b1, 8'h3C, 1'b1);
    idle_cycles(2 * FRAME + 4);

    // Fill and overflow: six consecutive writes, the sixth is dropped.
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b1);
    compared++;
    assert (uart_busy === 1'b1) else begin
      mismatched++;
      $error("FAIL fill_busy observed=%b expected=1", uart_busy);
    end
    idle_cycles(5 * FRAME + 4);

    // Push on the exact edge STOP ends while three bytes are buffered.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b1);
    guard = 0;
    while (!(m_in_frame && (edge_cnt + 1 - m_start == FRAME)) && guard < 200) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    compared++;
    assert (guard < 200) else begin
      mismatched++;
      $error("FAIL stop_sync observed=%0d expected<200", guard);
    end
    cycle(1'b1, 8'h77, 1'b1);
    compared++;
    assert (uart_busy === 1'b0) else begin
      mismatched++;
      $error("FAIL boundary_busy observed=%b expected=0", uart_busy);
    end
    idle_cycles(5 * FRAME);

    // Reset during data bit 3 of 0xFF with two bytes queued.
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b1, 8'hBB, 1'b1);
    guard = 0;
    while (!(m_in_frame && (edge_cnt + 1 - m_start == 4 * CPB + 2)) && guard < 100) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    compared++;
    assert (guard < 100) else begin
      mismatched++;
      $error("FAIL bit3_sync observed=%0d expected<100", guard);
    end
    cycle(1'b0, 8'h00, 1'b0);
    compared++;
    assert (tx === 1'b1) else begin
      mismatched++;
      $error("FAIL reset_tx observed=%b expected=1", tx);
    end
    idle_cycles(2 * FRAME);

    // data_in toggles every cycle without a write during a frame of 0x81.
    cycle(1'b1, 8'h81, 1'b1);
    for (int i = 0; i < FRAME + 4; i++) cycle(1'b0, 8'($urandom), 1'b1);

    // Randomized traffic at several write densities, with a rare reset.
    for (int round = 0; round < 4; round++) begin
      pct = (round == 0) ? 2 : (round == 1) ? 10 : (round == 2) ? 40 : 90;
      for (int i = 0; i < 400; i++) begin
        cycle(1'($urandom_range(0, 99) < pct), 8'($urandom),
              1'($urandom_range(0, 499) != 0));
      end
    end
    idle_cycles(6 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
